// File: rtl/udp_tx_framer.sv
// udp_tx_framer: UDP/IPv4 Ethernet transmit framer.
// Streams preamble/SFD, MAC, IPv4 and UDP headers, payload read from the TX RAM,
// zero pad and CRC-32 FCS onto the MAC byte interface, then holds an
// inter-frame gap before reporting completion.
module udp_tx_framer #(
    parameter logic [47:0] BOARD_MAC  = 48'h000a3501fec0,
    parameter logic [31:0] BOARD_IP   = 32'hc0a80002,
    parameter logic [15:0] BOARD_PORT = 16'h1f90,
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        tx_start,
    input  logic [15:0] tx_data_length,
    input  logic [47:0] pc_mac,
    input  logic [31:0] pc_IP,
    input  logic [15:0] pc_port,
    output logic [8:0]  ram_rd_addr,
    input  logic [31:0] ram_data,
    output logic [7:0]  dataout,
    output logic        e_txen,
    output logic        tx_busy,
    output logic        tx_done,
    output logic [3:0]  tx_state
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] CHKSUM   = 4'd1;
    localparam logic [3:0] PREAMBLE = 4'd2;
    localparam logic [3:0] MAC      = 4'd3;
    localparam logic [3:0] TYPE     = 4'd4;
    localparam logic [3:0] IP_HDR   = 4'd5;
    localparam logic [3:0] UDP_HDR  = 4'd6;
    localparam logic [3:0] DATA     = 4'd7;
    localparam logic [3:0] PAD      = 4'd8;
    localparam logic [3:0] FCS      = 4'd9;
    localparam logic [3:0] IFG      = 4'd10;

    logic [3:0]       state;
    logic [10:0]      cnt;
    logic [15:0]      len_l;
    logic [47:0]      mac_l;
    logic [31:0]      ip_l;
    logic [15:0]      port_l;
    logic [15:0]      ip_id;
    logic [31:0]      acc;
    logic [15:0]      chk;
    logic [31:0]      crc;
    logic [23:0]      hold;
    logic [15:0]      tot_len;
    logic [10:0]      plen;
    logic [41:0][7:0] hdr;
    logic [7:0]       nxt_byte;
    logic             nxt_en;
    logic             crc_en;

    function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int unsigned i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hedb88320) : (r >> 1);
        return r;
    endfunction

    assign tot_len  = len_l + 16'd20;
    assign plen     = 11'(len_l - 16'd8);
    assign tx_state = state;

    // MAC, TYPE, IP_HDR and UDP_HDR share one running byte index (0..41) into this vector
    assign hdr = {mac_l, BOARD_MAC, 16'h0800,
                  16'h4500, tot_len, ip_id, 16'h4000, 16'h8011, chk, BOARD_IP, ip_l,
                  BOARD_PORT, port_l, len_l, 16'h0000};

    // Select the byte to register onto the MAC interface this cycle
    always_comb begin
        nxt_byte = '0;
        nxt_en   = 1'b0;
        crc_en   = 1'b0;
        case (state)
            PREAMBLE: begin
                nxt_en   = 1'b1;
                nxt_byte = (cnt == 11'd7) ? 8'hd5 : 8'h55;
            end
            MAC, TYPE, IP_HDR, UDP_HDR: begin
                nxt_en   = 1'b1;
                crc_en   = 1'b1;
                nxt_byte = hdr[6'd41 - cnt[5:0]];
            end
            DATA: begin
                nxt_en   = 1'b1;
                crc_en   = 1'b1;
                nxt_byte = (cnt[1:0] == 2'd0) ? ram_data[31:24] : hold[23:16];
            end
            PAD: begin
                nxt_en = 1'b1;
                crc_en = 1'b1;
            end
            FCS: begin
                nxt_en = 1'b1;
                case (cnt[1:0])
                    2'd0:    nxt_byte = ~crc[7:0];
                    2'd1:    nxt_byte = ~crc[15:8];
                    2'd2:    nxt_byte = ~crc[23:16];
                    default: nxt_byte = ~crc[31:24];
                endcase
            end
            default: ;
        endcase
    end

    // Frame sequencer, header checksum, CRC accumulation and registered outputs
    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            cnt         <= '0;
            dataout     <= '0;
            e_txen      <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            ram_rd_addr <= '0;
            ip_id       <= '0;
            len_l       <= '0;
            mac_l       <= '0;
            ip_l        <= '0;
            port_l      <= '0;
            acc         <= '0;
            chk         <= '0;
            crc         <= '1;
            hold        <= '0;
        end else begin
            dataout <= nxt_byte;
            e_txen  <= nxt_en;
            tx_done <= 1'b0;
            if (crc_en)
                crc <= crc8(crc, nxt_byte);
            case (state)
                IDLE: begin
                    if (tx_start && tx_data_length >= 16'd9 && tx_data_length <= 16'd1480) begin
                        len_l   <= tx_data_length;
                        mac_l   <= pc_mac;
                        ip_l    <= pc_IP;
                        port_l  <= pc_port;
                        tx_busy <= 1'b1;
                        cnt     <= '0;
                        state   <= CHKSUM;
                    end
                end
                CHKSUM: begin
                    cnt <= cnt + 11'd1;
                    case (cnt[1:0])
                        2'd0: begin
                            acc <= 32'h4500 + 32'(tot_len) + 32'(ip_id) + 32'h4000 + 32'h8011;
                            ram_rd_addr <= '0;
                            crc <= '1;
                        end
                        2'd1: acc <= acc + 32'(BOARD_IP[31:16]) + 32'(BOARD_IP[15:0])
                                         + 32'(ip_l[31:16]) + 32'(ip_l[15:0]);
                        2'd2: acc <= 32'(acc[15:0]) + 32'(acc[31:16]);
                        default: begin
                            chk   <= ~(acc[15:0] + acc[31:16]);
                            cnt   <= '0;
                            state <= PREAMBLE;
                        end
                    endcase
                end
                PREAMBLE: begin
                    cnt <= cnt + 11'd1;
                    if (cnt == 11'd7) begin
                        cnt   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    cnt <= cnt + 11'd1;
                    if (cnt == 11'd11) state <= TYPE;
                end
                TYPE: begin
                    cnt <= cnt + 11'd1;
                    if (cnt == 11'd13) state <= IP_HDR;
                end
                IP_HDR: begin
                    cnt <= cnt + 11'd1;
                    if (cnt == 11'd33) state <= UDP_HDR;
                end
                UDP_HDR: begin
                    cnt <= cnt + 11'd1;
                    if (cnt == 11'd41) begin
                        cnt   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    // Next word is addressed while the current one is first used, so it
                    // is on ram_data by the following word's first byte; lanes 1..3 come
                    // from the held copy.
                    cnt <= cnt + 11'd1;
                    if (cnt[1:0] == 2'd0) begin
                        hold <= ram_data[23:0];
                        if ((cnt + 11'd4) < plen)
                            ram_rd_addr <= ram_rd_addr + 9'd1;
                    end else begin
                        hold <= {hold[15:0], 8'h00};
                    end
                    if (cnt == plen - 11'd1) begin
                        if (plen < 11'd18) begin
                            state <= PAD;
                        end else begin
                            cnt   <= '0;
                            state <= FCS;
                        end
                    end
                end
                PAD: begin
                    // cnt continues from the payload count, so pad ends at byte 17
                    cnt <= cnt + 11'd1;
                    if (cnt == 11'd17) begin
                        cnt   <= '0;
                        state <= FCS;
                    end
                end
                FCS: begin
                    cnt <= cnt + 11'd1;
                    if (cnt == 11'd3) begin
                        cnt   <= '0;
                        state <= IFG;
                    end
                end
                IFG: begin
                    cnt <= cnt + 11'd1;
                    if (cnt == 11'(IFG_CYCLES - 1)) begin
                        cnt     <= '0;
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                        ip_id   <= ip_id + 16'd1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_framer.sv
// tb_udp_tx_framer: scoreboard bench for udp_tx_framer. Expected frames, with the
// IP checksum and CRC-32 produced by the bench's own reference model, are queued at
// each request and popped as the DUT drives bytes with e_txen high.
module tb_udp_tx_framer;

    localparam logic [47:0] B_MAC  = 48'h000a3501fec0;
    localparam logic [31:0] B_IP   = 32'hc0a80002;
    localparam logic [15:0] B_PORT = 16'h1f90;
    localparam int unsigned IFG    = 12;

    logic        clk = 1'b0;
    logic        clr;
    logic        tx_start;
    logic [15:0] tx_data_length;
    logic [47:0] pc_mac;
    logic [31:0] pc_IP;
    logic [15:0] pc_port;
    logic [8:0]  ram_rd_addr;
    logic [31:0] ram_data;
    logic [7:0]  dataout;
    logic        e_txen;
    logic        tx_busy;
    logic        tx_done;
    logic [3:0]  tx_state;

    udp_tx_framer #(
        .BOARD_MAC (B_MAC),
        .BOARD_IP  (B_IP),
        .BOARD_PORT(B_PORT),
        .IFG_CYCLES(IFG)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .tx_start      (tx_start),
        .tx_data_length(tx_data_length),
        .pc_mac        (pc_mac),
        .pc_IP         (pc_IP),
        .pc_port       (pc_port),
        .ram_rd_addr   (ram_rd_addr),
        .ram_data      (ram_data),
        .dataout       (dataout),
        .e_txen        (e_txen),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_state      (tx_state)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:511];
    always @(posedge clk) ram_data <= mem[ram_rd_addr];

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  cap[$];
    int unsigned frame_bytes, runs, low_run, last_gap, max_addr;
    bit          prev_en = 1'b0;
    bit          saw_pad;
    bit          seen [0:511];
    logic [15:0] exp_id = 16'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte monitor: pops the scoreboard and gathers per-frame statistics
    always @(negedge clk) begin
        if (e_txen) begin
            if (!prev_en) begin
                runs++;
                last_gap = low_run;
            end
            low_run = 0;
            frame_bytes++;
            cap.push_back(dataout);
            check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("tx_byte", {24'h0, dataout}, {24'h0, exp_q.pop_front()});
        end else begin
            low_run++;
        end
        prev_en = e_txen;
        if (tx_state == 4'd8) saw_pad = 1'b1;
        if (tx_state >= 4'd2 && tx_state <= 4'd10) begin
            seen[ram_rd_addr] = 1'b1;
            if (32'(ram_rd_addr) > max_addr) max_addr = 32'(ram_rd_addr);
        end
    end

    task automatic push_frame(input logic [15:0] len, input logic [47:0] mac,
                              input logic [31:0] ip, input logic [15:0] port,
                              input logic [15:0] id);
        logic [7:0]  f[$];
        logic [31:0] sum, c, nc, w, bip;
        logic [47:0] bmac;
        logic [15:0] tl, cks, bport;
        int unsigned p;
        bip = B_IP; bmac = B_MAC; bport = B_PORT;
        tl = len + 16'd20;
        p  = 32'(len) - 8;
        sum = 32'h4500 + 32'(tl) + 32'(id) + 32'h4000 + 32'h8011
            + 32'(bip[31:16]) + 32'(bip[15:0]) + 32'(ip[31:16]) + 32'(ip[15:0]);
        while (sum[31:16] != 16'h0) sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
        cks = ~sum[15:0];
        for (int i = 0; i < 6; i++) f.push_back(mac[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) f.push_back(bmac[47-8*i -: 8]);
        f.push_back(8'h08); f.push_back(8'h00);
        f.push_back(8'h45); f.push_back(8'h00); f.push_back(tl[15:8]); f.push_back(tl[7:0]);
        f.push_back(id[15:8]); f.push_back(id[7:0]); f.push_back(8'h40); f.push_back(8'h00);
        f.push_back(8'h80); f.push_back(8'h11); f.push_back(cks[15:8]); f.push_back(cks[7:0]);
        for (int i = 0; i < 4; i++) f.push_back(bip[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) f.push_back(ip[31-8*i -: 8]);
        f.push_back(bport[15:8]); f.push_back(bport[7:0]);
        f.push_back(port[15:8]); f.push_back(port[7:0]);
        f.push_back(len[15:8]); f.push_back(len[7:0]);
        f.push_back(8'h00); f.push_back(8'h00);
        for (int i = 0; i < int'(p); i++) begin
            w = mem[i/4];
            f.push_back(w[31-8*(i%4) -: 8]);
        end
        for (int i = int'(p); i < 18; i++) f.push_back(8'h00);
        c = 32'hffffffff;
        foreach (f[i]) begin
            c = c ^ {24'h0, f[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
        end
        nc = ~c;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hd5);
        foreach (f[i]) exp_q.push_back(f[i]);
        exp_q.push_back(nc[7:0]); exp_q.push_back(nc[15:8]);
        exp_q.push_back(nc[23:16]); exp_q.push_back(nc[31:24]);
    endtask

    task automatic clear_stats();
        frame_bytes = 0; runs = 0; saw_pad = 1'b0; max_addr = 0;
        cap.delete();
        for (int i = 0; i < 512; i++) seen[i] = 1'b0;
    endtask

    task automatic do_frame(input logic [15:0] len, input bit hold, input bit pulse);
        int unsigned n, p;
        p = 32'(len) - 8;
        push_frame(len, pc_mac, pc_IP, pc_port, exp_id);
        clear_stats();
        tx_data_length = len;
        tx_start = 1'b1;
        @(posedge clk); #1;
        if (!hold) tx_start = 1'b0;
        check("accept_busy", 32'(tx_busy), 32'd1);
        check("accept_state", 32'(tx_state), 32'd1);
        n = 0;
        while (!e_txen && n < 20) begin @(posedge clk); #1; n++; end
        check("txen_latency", n, 32'd5);
        if (pulse) begin tx_start = 1'b1; @(posedge clk); #1; tx_start = 1'b0; end
        n = 0;
        while (e_txen && n < 3000) begin @(posedge clk); #1; n++; end
        n = 1;
        while (!tx_done && n < 100) begin @(posedge clk); #1; n++; end
        check("ifg_cycles", n, IFG);
        check("busy_at_done", 32'(tx_busy), 32'd0);
        check("txen_bytes", frame_bytes, 32'(8 + 42 + ((p < 18) ? 18 : p) + 4));
        check("txen_runs", runs, 32'd1);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("pad_state", 32'(saw_pad), 32'(p < 18));
        exp_id++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned n, cnt_seen;
        mem[0] = 32'h01020304;
        mem[1] = 32'h05060708;
        for (int i = 2; i < 512; i++) mem[i] = $urandom;
        clr = 1'b1; tx_start = 1'b0; tx_data_length = 16'd16;
        pc_mac = 48'h001122334455; pc_IP = 32'hc0a80003; pc_port = 16'h1388;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dataout", 32'(dataout), 32'd0);
        check("rst_txen", 32'(e_txen), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_addr", 32'(ram_rd_addr), 32'd0);
        check("rst_state", 32'(tx_state), 32'd0);
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic frame, tx_start held high so the next frame follows straight after tx_done
        do_frame(16'd16, 1'b1, 1'b0);
        check("basic_cks_hi", 32'(cap[32]), 32'h79);
        check("basic_cks_lo", 32'(cap[33]), 32'h73);
        for (int i = 0; i < 8; i++) check("basic_payload", 32'(cap[50+i]), 32'(i + 1));
        check("basic_id_lo", 32'(cap[27]), 32'h00);

        // Second frame accepted from the held request; mid-frame pulse must be ignored
        do_frame(16'd16, 1'b0, 1'b1);
        check("b2b_gap", last_gap, 32'(IFG + 5));
        check("b2b_id_lo", 32'(cap[27]), 32'h01);

        pc_mac = 48'hfeedfacecafe; pc_IP = 32'h0a000001; pc_port = 16'h0035;
        do_frame(16'd13, 1'b0, 1'b0);
        check("odd_last_byte", 32'(cap[54]), 32'h05);
        do_frame(16'd9, 1'b0, 1'b0);

        do_frame(16'd1480, 1'b0, 1'b0);
        cnt_seen = 0;
        for (int i = 0; i < 512; i++) if (seen[i]) cnt_seen++;
        check("max_addr_count", cnt_seen, 32'd368);
        check("max_addr_top", max_addr, 32'd367);

        // Illegal lengths must be ignored
        for (int k = 0; k < 2; k++) begin
            tx_data_length = (k == 0) ? 16'd8 : 16'd1481;
            tx_start = 1'b1;
            repeat (4) begin
                @(posedge clk); #1;
                check("bad_len_busy", 32'(tx_busy), 32'd0);
                check("bad_len_txen", 32'(e_txen), 32'd0);
            end
            tx_start = 1'b0;
        end

        // Reset in the middle of DATA abandons the frame and clears the IP ID
        push_frame(16'd100, pc_mac, pc_IP, pc_port, exp_id);
        clear_stats();
        tx_data_length = 16'd100;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        n = 0;
        while (tx_state != 4'd7 && n < 200) begin @(posedge clk); #1; n++; end
        check("rst_reach_data", 32'(tx_state), 32'd7);
        repeat (6) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("midrst_txen", 32'(e_txen), 32'd0);
        check("midrst_state", 32'(tx_state), 32'd0);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        check("midrst_addr", 32'(ram_rd_addr), 32'd0);
        check("midrst_dataout", 32'(dataout), 32'd0);
        exp_q.delete();
        exp_id = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_quiet", 32'(e_txen), 32'd0);
        do_frame(16'd40, 1'b0, 1'b0);
        check("midrst_id_lo", 32'(cap[27]), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
